// File: rtl/rx_intf.sv
// Single-rail to four-phase dual-rail NoC transmitter: encodes core words onto rx_d and
// waits for the consumer's return-to-zero handshake. Define RX_INTF_FIFO_EN for a 2-entry input FIFO.
module rx_intf #(
  parameter int NOC_WID = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NOC_WID-1:0]     in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [2*NOC_WID-1:0]   rx_d,
  input  logic                   rx_ack
);

  // Core side: a word transfers on a rising edge where in_valid && in_ready are both 1;
  // in_data must be held while in_valid is high and in_ready is low.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    NULL_WAIT = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [2*NOC_WID-1:0]   rx_d_nxt;
  logic                   ack_m;
  logic                   ack_s;
  logic                   word_avail;
  logic [NOC_WID-1:0]     word;
  logic                   launch;

  function automatic logic [2*NOC_WID-1:0] dr_encode(input logic [NOC_WID-1:0] w);
    logic [2*NOC_WID-1:0] d;
    for (int j = 0; j < NOC_WID; j++) begin
      d[2*j+1] = w[j];
      d[2*j]   = ~w[j];
    end
    return d;
  endfunction

  // rx_ack is asynchronous to clk; only ack_s is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= rx_ack;
      ack_s <= ack_m;
    end
  end

`ifdef RX_INTF_FIFO_EN
  logic [NOC_WID-1:0] fifo_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               push;
  logic               pop;

  assign in_ready   = rst_n && (count != 2'd2);
  assign push       = in_valid && in_ready;
  assign pop        = launch;
  assign word_avail = (count != 2'd0);
  assign word       = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end
`else
  assign in_ready   = rst_n && (state == IDLE) && !ack_s;
  assign word_avail = in_valid && in_ready;
  assign word       = in_data;
`endif

  always_comb begin
    state_nxt = state;
    rx_d_nxt  = rx_d;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        rx_d_nxt = '0;
        if (word_avail && !ack_s) begin
          launch    = 1'b1;
          rx_d_nxt  = dr_encode(word);
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (ack_s) begin
          rx_d_nxt  = '0;
          state_nxt = NULL_WAIT;
        end
      end
      NULL_WAIT: begin
        rx_d_nxt = '0;
        if (!ack_s) state_nxt = IDLE;
      end
      default: begin
        rx_d_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rx_d  <= '0;
    end else begin
      state <= state_nxt;
      rx_d  <= rx_d_nxt;
    end
  end

endmodule

// File: tb/tb_rx_intf.sv
// Directed bench for rx_intf (NOC_WID=4): reset, handshake timing, stale ack,
// async reset mid-handshake, FIFO fill (RX_INTF_FIFO_EN) and a 100-word loopback decode.
`timescale 1ns/1ps
module tb_rx_intf;
  localparam int W = 4;
`ifdef RX_INTF_FIFO_EN
  localparam int FIFO = 1;
`else
  localparam int FIFO = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] rx_d;
  logic           rx_ack = 1'b0;

  rx_intf #(.NOC_WID(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rx_d     (rx_d),
    .rx_ack   (rx_ack)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass = 0;
  int           n_rx = 0;
  bit           auto_ack = 1'b0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   data;
    logic [2*W-1:0] exp_d;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full manual handshake for one word with hand-computed encoding.
  task automatic send_word(input logic [W-1:0] data, input logic [2*W-1:0] exp_d, input string name);
    int cyc;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({name, "_ready"}, in_ready, 1);
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = ~data;
    if (FIFO != 0) tick();
    check({name, "_data"}, rx_d, exp_d);
    tick();
    check({name, "_hold"}, rx_d, exp_d);
    rx_ack = 1'b1;
    tick();
    check({name, "_ack1"}, rx_d, exp_d);
    tick();
    check({name, "_ack2"}, rx_d, exp_d);
    tick();
    check({name, "_null"}, rx_d, 0);
    rx_ack = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // Hold in_valid until the word is taken on an edge where in_ready was high.
  task automatic push_wait(input logic [W-1:0] w, input string name);
    bit acc;
    int cyc;
    acc = 1'b0;
    cyc = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!acc && cyc < 60) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (!acc) check({name, "_accept_timeout"}, 0, 1);
  endtask

  // Dual-rail consumer: decode complete words, ack, release ack on NULL.
  initial forever begin
    @(posedge clk);
    #2;
    if (auto_ack) begin
      if (!rx_ack && rx_d != '0) begin
        logic [W-1:0] got;
        bit ok;
        ok = 1'b1;
        got = '0;
        for (int j = 0; j < W; j++) begin
          if (rx_d[2*j+1] && !rx_d[2*j]) got[j] = 1'b1;
          else if (!rx_d[2*j+1] && rx_d[2*j]) got[j] = 1'b0;
          else ok = 1'b0;
        end
        check("rx_complete", ok, 1);
        check("rx_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("rx_word", got, exp_q.pop_front());
        n_rx++;
        rx_ack = 1'b1;
      end else if (rx_ack && rx_d == '0) begin
        rx_ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vecs[0] = '{4'b0000, 8'b01010101};
    vecs[1] = '{4'b1111, 8'b10101010};
    vecs[2] = '{4'b1010, 8'b10011001};
    vecs[3] = '{4'b0011, 8'b01011010};
    vecs[4] = '{4'b1100, 8'b10100101};
    vecs[5] = '{4'b0101, 8'b01100110};

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rx_d", rx_d, 0);
      check("rst_ready", in_ready, 0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", in_ready, 1);

    // First word, ack raised 5 cycles after acceptance.
    in_data  = 4'b1001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 4'b0000;
    if (FIFO != 0) tick();
    for (int i = 0; i < 5; i++) begin
      check("w1_hold", rx_d, 8'b10010110);
      tick();
    end
    rx_ack = 1'b1;
    tick();
    check("w1_ack1", rx_d, 8'b10010110);
    tick();
    check("w1_ack2", rx_d, 8'b10010110);
    tick();
    check("w1_null", rx_d, 0);
    check("w1_ready_nullwait", in_ready, FIFO);
    rx_ack = 1'b0;
    tick();
    check("w1_null_hold", rx_d, 0);
    tick();
    check("w1_ready_sync", in_ready, FIFO);
    tick();
    check("w1_ready_idle", in_ready, 1);
    send_word(4'b0110, 8'b01101001, "w2");

    for (int i = 0; i < 6; i++) send_word(vecs[i].data, vecs[i].exp_d, $sformatf("vec%0d", i));

    // Stale ack out of reset.
    rst_n  = 1'b0;
    rx_ack = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
`ifdef RX_INTF_FIFO_EN
    in_data  = 4'b1100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stale_rx_d", rx_d, 0);
      check("stale_ready", in_ready, 1);
    end
`else
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 4'(i + 1);
      tick();
      check("stale_rx_d", rx_d, 0);
      check("stale_ready", in_ready, 0);
    end
    in_data = 4'b1100;
`endif
    rx_ack = 1'b0;
    tick();
    check("stale_drop1", rx_d, 0);
    tick();
    check("stale_drop2", rx_d, 0);
    tick();
    in_valid = 1'b0;
    check("stale_launch", rx_d, 8'b10100101);
    rx_ack = 1'b1;
    tick();
    tick();
    tick();
    check("stale_null", rx_d, 0);
    rx_ack = 1'b0;
    tick();
    tick();
    tick();

    // Asynchronous reset in the middle of a handshake discards everything.
    in_data  = 4'b0101;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (FIFO != 0) tick();
    check("mid_data", rx_d, 8'b01100110);
    in_data  = 4'b1111;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rx_d", rx_d, 0);
    check("mid_rst_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_discard", rx_d, 0);
    end

`ifdef RX_INTF_FIFO_EN
    // FIFO fill with the consumer stalled, then release in order.
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    in_data  = 4'b0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("fifo_head_data", rx_d, 8'b01010110);
    check("fifo_ready0", in_ready, 1);
    in_data  = 4'b0010;
    in_valid = 1'b1;
    tick();
    check("fifo_ready1", in_ready, 1);
    in_data = 4'b0100;
    tick();
    check("fifo_ready_full", in_ready, 0);
    in_data = 4'b1000;
    tick();
    check("fifo_full_hold", in_ready, 0);
    check("fifo_full_rx_d", rx_d, 8'b01010110);
    auto_ack = 1'b1;
    n_rx = 0;
    push_wait(4'b1000, "fifo_w3");
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("fifo_drained", exp_q.size(), 0);
    check("fifo_rx_count", n_rx, 4);
    for (int i = 0; i < 8; i++) tick();
`endif

    // Loopback of 100 random words through the dual-rail decoder.
    auto_ack = 1'b1;
    n_rx = 0;
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] w;
      w = W'($urandom_range(0, 15));
      exp_q.push_back(w);
      push_wait(w, "lb");
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < 10; i++) tick();
    check("lb_drained", exp_q.size(), 0);
    check("lb_rx_count", n_rx, 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
